// File: rtl/clk_div_multi_pkg.sv
// Shared definitions for the multi-channel clock divider: channel FSM
// encodings and the smallest divisor a channel is allowed to run with.
package clk_div_multi_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // Divisors 0 and 1 cannot produce a square wave, so 2 is the floor.
    localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_multi_ch.sv
// One divider channel: IDLE/RUN FSM, period counter and a divisor latched at
// each period start so mid-period divisor changes wait for the boundary.
module clk_div_ch
    import clk_div_multi_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [CNT_W-1:0] div,
    output logic             out,
    output logic             tick,
    output logic             active
);

    ch_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] act, act_nxt;
    logic             out_q, out_nxt;
    logic             tick_q, tick_nxt;
    logic             div_ok;
    logic             period_end;
    logic [CNT_W-1:0] cnt_inc;

    assign div_ok     = (div >= CNT_W'(DIV_MIN));
    assign period_end = (cnt == (act - CNT_W'(1)));
    assign cnt_inc    = cnt + CNT_W'(1);

    // State register: FSM state plus the registered outputs it drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            act    <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            act    <= act_nxt;
            out_q  <= out_nxt;
            tick_q <= tick_nxt;
        end
    end

    // Next-state logic. In RUN, en has priority over sync and period end.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        act_nxt   = act;
        out_nxt   = 1'b0;
        tick_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (en && div_ok) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    act_nxt   = div;
                    out_nxt   = 1'b1;
                    tick_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (sync || period_end) begin
                    if (div_ok) begin
                        cnt_nxt  = '0;
                        act_nxt  = div;
                        out_nxt  = 1'b1;
                        tick_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    out_nxt = (cnt_inc < (act >> 1));
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: active mirrors the registered state directly.
    always_comb begin
        out    = out_q;
        tick   = tick_q;
        active = (state == ST_RUN);
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels,
// each with its own enable and divisor, phase-aligned by a shared sync.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       active
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en[i]),
            .sync   (sync),
            .div    (div_in[i*CNT_W +: CNT_W]),
            .out    (out[i]),
            .tick   (tick[i]),
            .active (active[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: waveform shape, divisor latching, sync
// alignment, invalid divisors, enable drop and asynchronous reset.
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic                    sync;
    logic [NUM_CH-1:0]       out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       active;

    int checks;
    int errors;

    clk_div_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .div_in (div_in),
        .sync   (sync),
        .out    (out),
        .tick   (tick),
        .active (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_div(input int ch, input int val);
        div_in[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    // Checks n cycles of a freshly started channel: k counts cycles since tick.
    task automatic run_pattern(input string tag, input int ch, input int d, input int n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_out"},    32'(out[ch]),    32'((k % d) < (d / 2)));
            chk({tag, "_tick"},   32'(tick[ch]),   32'((k % d) == 0));
            chk({tag, "_active"}, 32'(active[ch]), 32'd1);
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = '0;
        div_in = '0;
        sync   = 1'b0;
        #1;
        chk("reset_out",    32'(out),    32'd0);
        chk("reset_tick",   32'(tick),   32'd0);
        chk("reset_active", 32'(active), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_active", 32'(active), 32'd0);

        // Channel 0, divisor 4: out 1,1,0,0 and tick every 4 cycles.
        set_div(0, 4);
        en[0] = 1'b1;
        step();
        run_pattern("div4", 0, 4, 12);

        // Enable drop mid-period: all outputs low one edge later.
        step();
        en[0] = 1'b0;
        step();
        chk("endrop_out",    32'(out[0]),    32'd0);
        chk("endrop_tick",   32'(tick[0]),   32'd0);
        chk("endrop_active", 32'(active[0]), 32'd0);

        // Channel 1, odd divisor 5: high 2, low 3.
        set_div(1, 5);
        en[1] = 1'b1;
        step();
        run_pattern("div5", 1, 5, 10);
        en[1] = 1'b0;
        step();

        // Channel 2, minimum divisor: alternating with tick every 2 cycles.
        set_div(2, 2);
        en[2] = 1'b1;
        step();
        run_pattern("div2", 2, 2, 6);
        en[2] = 1'b0;
        step();

        // Divisor 8 changed to 4 at cnt=2: ticks at k=0, 8, 12, 16.
        set_div(0, 8);
        en[0] = 1'b1;
        step();
        for (int k = 0; k < 18; k++) begin
            chk("divchg_tick", 32'(tick[0]), 32'((k == 0) || (k == 8) || (k == 12) || (k == 16)));
            chk("divchg_out",  32'(out[0]),  32'((k < 8) ? (k < 4) : (((k - 8) % 4) < 2)));
            if (k == 2) set_div(0, 4);
            step();
        end
        en[0] = 1'b0;
        step();

        // Sync: channels at 6 and 10, started out of phase, restart together.
        set_div(0, 6);
        set_div(1, 10);
        en[0] = 1'b1;
        step();
        step();
        en[1] = 1'b1;
        for (int k = 0; k < 5; k++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("sync_tick0", 32'(tick[0]), 32'((k % 6) == 0));
            chk("sync_out0",  32'(out[0]),  32'((k % 6) < 3));
            chk("sync_tick1", 32'(tick[1]), 32'((k % 10) == 0));
            chk("sync_out1",  32'(out[1]),  32'((k % 10) < 5));
            step();
        end
        en = '0;
        step();

        // Invalid divisors from IDLE: channel never starts.
        set_div(3, 0);
        en[3] = 1'b1;
        step();
        step();
        chk("div0_active", 32'(active[3]), 32'd0);
        chk("div0_out",    32'(out[3]),    32'd0);
        chk("div0_tick",   32'(tick[3]),   32'd0);
        set_div(3, 1);
        step();
        step();
        chk("div1_active", 32'(active[3]), 32'd0);
        chk("div1_out",    32'(out[3]),    32'd0);
        chk("div1_tick",   32'(tick[3]),   32'd0);

        // Divisor dropped to 1 while running: stops at the period end.
        set_div(3, 4);
        step();
        chk("drop_start_tick", 32'(tick[3]), 32'd1);
        set_div(3, 1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("drop_run_active", 32'(active[3]), 32'd1);
        end
        step();
        chk("drop_end_active", 32'(active[3]), 32'd0);
        chk("drop_end_out",    32'(out[3]),    32'd0);
        chk("drop_end_tick",   32'(tick[3]),   32'd0);
        en = '0;
        step();

        // Asynchronous reset between edges clears outputs without a clock.
        set_div(0, 4);
        en[0] = 1'b1;
        step();
        step();
        chk("prerst_active", 32'(active[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out",    32'(out),    32'd0);
        chk("arst_tick",   32'(tick),   32'd0);
        chk("arst_active", 32'(active), 32'd0);
        step();
        rst_n = 1'b1;
        en    = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
